seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIG, default 8, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DIV_W, default 8, prescaler width; digit dwell = 2^DIV_W clk cycles (legal >= 3).
REQ-003 SHALL have parameter BLINK_W, default 6, blink phase toggles every 2^BLINK_W frames.
REQ-004 SHALL have parameter ACT_LOW, default 1, 1 = seg_o/dp_o/an_o active-low, 0 = active-high.
REQ-005 SHALL have port clk  in  1  system clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cell_i  in  8*N_DIG  raw digit k = {dp, seg[6:0]} at bits [8k+7:8k], 1 = lit.
REQ-008 SHALL have port hex_i  in  4*N_DIG  hex nibble for digit k at [4k+3:4k].
REQ-009 SHALL have port mode_i  in  N_DIG  per digit: 1 = hex decode, 0 = raw cell.
REQ-010 SHALL have port en_i  in  N_DIG  per digit: 0 = blanked.
REQ-011 SHALL have port blink_i  in  N_DIG  per digit blink enable.
REQ-012 SHALL have port bright_i  in  3  brightness, duty = (bright_i+1)/8.
REQ-013 SHALL have port load_i  in  1  request capture of all digit inputs.
REQ-014 SHALL have port load_ack_o  out  1  one-cycle pulse, capture done.
REQ-015 SHALL have port frame_o  out  1  one-cycle pulse at each frame boundary.
REQ-016 SHALL have ports seg_o out 7, dp_o out 1, an_o out N_DIG: display pins.

Function
REQ-017 Prescaler SHALL increment every clk, wrapping at all-ones.
REQ-018 Digit index SHALL advance on prescaler wrap: 0,1..N_DIG-1, then 0.
REQ-019 Frame boundary SHALL be the cycle with prescaler all-ones and index N_DIG-1; frame_o SHALL pulse on the following cycle.
REQ-020 load_i SHALL set a pending flag; at a frame boundary with pending or load_i high, shadow registers SHALL capture cell_i, hex_i, mode_i, en_i, blink_i, pending SHALL clear, load_ack_o SHALL pulse the next cycle.
REQ-021 Display SHALL use shadow registers only; bright_i SHALL be sampled live.
REQ-022 Hex decode SHALL map 0-F to standard glyphs, seg[6:0] = {g,f,e,d,c,b,a}; dp SHALL come from cell bit 7 in both modes.
REQ-023 Digit SHALL be lit when en=1, prescaler != 0, prescaler[DIV_W-1:DIV_W-3] <= bright_i, and not (blink=1 and blink phase off).
REQ-024 Prescaler == 0 SHALL force all anodes inactive (ghosting guard).
REQ-025 When lit, exactly the index anode SHALL be active with decoded segments; otherwise all anodes, seg_o, dp_o inactive.
REQ-026 All display outputs SHALL be registered: one-cycle latency from prescaler/index to pins.
REQ-027 Blink frame counter SHALL wrap at 2^BLINK_W-1 and toggle phase on that frame boundary.

Reset
REQ-028 rst low SHALL clear prescaler, index, blink counter, pending flag, shadows to 0; blink phase = visible.
REQ-029 During and after reset, an_o/seg_o/dp_o SHALL be at inactive level per ACT_LOW; load_ack_o, frame_o = 0.
REQ-030 Reset mid-frame SHALL discard pending loads; display stays blank until first post-reset load (shadow en = 0).

Structure
REQ-031 Hex glyph table and polarity helper SHALL live in shared package seg_pkg.
REQ-032 Decode SHALL be one sub-module, seg_hex_decode (nibble -> 7 segments), combinational.

Verification
REQ-033 N_DIG=4, DIV_W=4: load cell_i=32'h86_5B_4F_66, mode_i=0, en_i=F, bright_i=7 -> an_o cycles E,D,B,7 for 15 cycles each with 1 blank cycle, seg_o = inverted cell.
REQ-034 hex_i=16'h1A3F, mode_i=F -> digit0 seg_o = ~7'h71, digit3 ~7'h06.
REQ-035 load_i pulse mid-frame with new data -> old data shown to frame end; load_ack_o and new data one cycle after boundary.
REQ-036 bright_i=1 -> each digit lit 3 of 16 dwell cycles (prescaler 1..3).
REQ-037 BLINK_W=1, blink_i=1 on digit 2 -> digit 2 dark on alternate pairs of frames, others unaffected.
REQ-038 rst asserted mid-dwell with load pending -> outputs inactive immediately; no load_ack_o after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared glyph table and pin-polarity helper for the
// multiplexed seven-segment scan controller.
package seg_pkg;

   localparam int SEG_W = 7;

   // seg[6:0] = {g,f,e,d,c,b,a}, 1 = lit
   function automatic logic [SEG_W-1:0] hex_glyph(
      input logic [3:0] n
   );
      logic [SEG_W-1:0] g;
      unique case (n)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         4'hF: g = 7'h71;
      endcase
      return g;
   endfunction

   function automatic logic [7:0] seg_pol8(
      input logic [7:0] v,
      input logic       act_low
   );
      return v ^ {8{act_low}};
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to seven-segment glyph decoder.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0]       i_nib,
   output logic [SEG_W-1:0] o_seg
);

   assign o_seg = hex_glyph(i_nib);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with shadowed
// digit data, PWM brightness and per-digit blink.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int N_DIG   = 8,
   parameter int DIV_W   = 8,
   parameter int BLINK_W = 6,
   parameter int ACT_LOW = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [8*N_DIG-1:0] cell_i,
   input  logic [4*N_DIG-1:0] hex_i,
   input  logic [N_DIG-1:0]   mode_i,
   input  logic [N_DIG-1:0]   en_i,
   input  logic [N_DIG-1:0]   blink_i,
   input  logic [2:0]         bright_i,
   input  logic               load_i,
   output logic               load_ack_o,
   output logic               frame_o,
   output logic [6:0]         seg_o,
   output logic               dp_o,
   output logic [N_DIG-1:0]   an_o
);

   localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_DIG - 1);
   localparam logic AL = (ACT_LOW != 0);

   logic [DIV_W-1:0]   r_pre;
   logic [IDX_W-1:0]   r_idx;
   logic [BLINK_W-1:0] r_bcnt;
   logic               r_bon;
   logic               r_pend;
   logic               r_ack;
   logic               r_frame;
   logic [8*N_DIG-1:0] r_cell;
   logic [4*N_DIG-1:0] r_hex;
   logic [N_DIG-1:0]   r_mode;
   logic [N_DIG-1:0]   r_en;
   logic [N_DIG-1:0]   r_blink;
   logic [6:0]         r_seg;
   logic               r_dp;
   logic [N_DIG-1:0]   r_an;

   logic       w_wrap;
   logic       w_fb;
   logic       w_cap;
   logic [7:0] w_cell;
   logic [3:0] w_nib;
   logic       w_mode;
   logic       w_en;
   logic       w_blk;
   logic [7:0] w_an1h;
   logic [6:0] w_glyph;
   logic [6:0] w_seg_ah;
   logic       w_lit;
   logic [7:0] w_pins;
   logic [7:0] w_anp;

   assign w_wrap = &r_pre;
   assign w_fb   = w_wrap && (r_idx == LAST);
   assign w_cap  = w_fb && (r_pend || load_i);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pre <= '0;
         r_idx <= '0;
      end else begin
         r_pre <= r_pre + DIV_W'(1);
         if (w_wrap)
            r_idx <= (r_idx == LAST) ? '0 : r_idx + IDX_W'(1);
      end
   end

   // Phase flips once the frame counter rolls over
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bcnt <= '0;
         r_bon  <= 1'b1;
      end else if (w_fb) begin
         r_bcnt <= r_bcnt + BLINK_W'(1);
         if (&r_bcnt)
            r_bon <= ~r_bon;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend  <= 1'b0;
         r_ack   <= 1'b0;
         r_frame <= 1'b0;
         r_cell  <= '0;
         r_hex   <= '0;
         r_mode  <= '0;
         r_en    <= '0;
         r_blink <= '0;
      end else begin
         r_ack   <= w_cap;
         r_frame <= w_fb;
         if (w_cap) begin
            r_pend  <= 1'b0;
            r_cell  <= cell_i;
            r_hex   <= hex_i;
            r_mode  <= mode_i;
            r_en    <= en_i;
            r_blink <= blink_i;
         end else if (load_i) begin
            r_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      w_cell = '0;
      w_nib  = '0;
      w_mode = 1'b0;
      w_en   = 1'b0;
      w_blk  = 1'b0;
      w_an1h = '0;
      for (int k = 0; k < N_DIG; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_cell    = r_cell[8*k +: 8];
            w_nib     = r_hex[4*k +: 4];
            w_mode    = r_mode[k];
            w_en      = r_en[k];
            w_blk     = r_blink[k];
            w_an1h[k] = 1'b1;
         end
      end
   end

   seg_hex_decode u_dec (
      .i_nib (w_nib),
      .o_seg (w_glyph)
   );

   // Prescaler zero is the dead slot between digits
   assign w_lit = w_en
               && (r_pre != '0)
               && (r_pre[DIV_W-1 -: 3] <= bright_i)
               && !(w_blk && !r_bon);

   assign w_seg_ah = w_mode ? w_glyph : w_cell[6:0];
   assign w_pins   = seg_pol8(w_lit ? {w_cell[7], w_seg_ah} : 8'h00, AL);
   assign w_anp    = seg_pol8(w_lit ? w_an1h : 8'h00, AL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seg <= {7{AL}};
         r_dp  <= AL;
         r_an  <= {N_DIG{AL}};
      end else begin
         r_seg <= w_pins[6:0];
         r_dp  <= w_pins[7];
         r_an  <= N_DIG'(w_anp);
      end
   end

   assign seg_o      = r_seg;
   assign dp_o       = r_dp;
   assign an_o       = r_an;
   assign load_ack_o = r_ack;
   assign frame_o    = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: 4 digits, 16-cycle dwell, 2-frame blink, active-low.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] cell_i;
   logic [15:0] hex_i;
   logic [3:0]  mode_i;
   logic [3:0]  en_i;
   logic [3:0]  blink_i;
   logic [2:0]  bright_i;
   logic        load_i;
   logic        load_ack_o;
   logic        frame_o;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic [3:0]  an_o;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .N_DIG   (4),
      .DIV_W   (4),
      .BLINK_W (1),
      .ACT_LOW (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cell_i     (cell_i),
      .hex_i      (hex_i),
      .mode_i     (mode_i),
      .en_i       (en_i),
      .blink_i    (blink_i),
      .bright_i   (bright_i),
      .load_i     (load_i),
      .load_ack_o (load_ack_o),
      .frame_o    (frame_o),
      .seg_o      (seg_o),
      .dp_o       (dp_o),
      .an_o       (an_o)
   );

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      int         len;
   } run_t;

   run_t runq[$];
   int   ackq[$];
   int   total = 0;
   int   bad   = 0;
   int   fcnt  = 0;
   logic [6:0] exp_seg [4];
   logic       exp_dp  [4];

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s", nm);
   endtask

   // Monitor: collapses each lit stretch into one run record
   logic [3:0] m_an;
   logic [6:0] m_seg;
   logic       m_dp;
   int         m_len = 0;
   int         fgap  = 0;
   bit         fseen = 0;

   always @(negedge clk) begin
      if (!rst)
         fseen = 0;
      if (load_ack_o) begin
         if (ackq.size() == 0)
            fail("ack_unexpected");
         else begin
            void'(ackq.pop_front());
            chk("ack_on_frame", 32'(frame_o), 32'd1);
         end
      end
      if (frame_o) begin
         if (fseen)
            chk("frame_period", fgap, 64);
         fseen = 1;
         fgap  = 0;
      end
      fgap++;
      if (m_len > 0 &&
          {an_o, seg_o, dp_o} != {m_an, m_seg, m_dp}) begin
         if (runq.size() == 0) begin
            fail("run_unexpected");
            $display("  got an=%h seg=%h dp=%b len=%0d",
                     m_an, m_seg, m_dp, m_len);
         end else begin
            run_t r;
            r = runq.pop_front();
            total++;
            if (m_an !== r.an || m_seg !== r.seg ||
                m_dp !== r.dp || m_len != r.len) begin
               bad++;
               $display("FAIL run: got an=%h seg=%h dp=%b len=%0d want an=%h seg=%h dp=%b len=%0d",
                        m_an, m_seg, m_dp, m_len,
                        r.an, r.seg, r.dp, r.len);
            end
         end
         m_len = 0;
      end
      if (an_o != 4'hF) begin
         if (m_len == 0) begin
            m_an  = an_o;
            m_seg = seg_o;
            m_dp  = dp_o;
         end
         m_len++;
      end else begin
         chk("blank_pins", {seg_o, dp_o}, 32'hFF);
      end
   end

   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_o && n < 200);
      if (!frame_o)
         fail("frame_timeout");
      fcnt++;
   endtask

   task automatic push_frame(input int len, input logic [3:0] vis);
      logic [3:0] a;
      for (int k = 0; k < 4; k++) begin
         if (vis[k]) begin
            a = 4'b0001 << k;
            a = ~a;
            runq.push_back('{an: a, seg: exp_seg[k],
                             dp: exp_dp[k], len: len});
         end
      end
   endtask

   task automatic pulse_load(input bit want_ack);
      load_i = 1'b1;
      @(negedge clk);
      load_i = 1'b0;
      if (want_ack)
         ackq.push_back(1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_an"},    32'(an_o),       32'hF);
      chk({tag, "_seg"},   32'(seg_o),      32'h7F);
      chk({tag, "_dp"},    32'(dp_o),       32'h1);
      chk({tag, "_ack"},   32'(load_ack_o), 32'h0);
      chk({tag, "_frame"}, 32'(frame_o),    32'h0);
   endtask

   initial begin
      load_i   = 1'b0;
      cell_i   = '0;
      hex_i    = '0;
      mode_i   = '0;
      en_i     = '0;
      blink_i  = '0;
      bright_i = 3'd7;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      #1 rst = 1'b1;
      fcnt = 0;

      // Raw cells, full brightness
      wait_frame();
      repeat (10) @(negedge clk);
      cell_i = 32'h865B4F66;
      mode_i = 4'h0;
      en_i   = 4'hF;
      pulse_load(1);
      exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
      exp_dp  = '{1'b1, 1'b1, 1'b1, 1'b0};
      wait_frame();
      push_frame(15, 4'hF);

      // Hex mode; live input change must wait for the boundary
      wait_frame();
      push_frame(15, 4'hF);
      repeat (10) @(negedge clk);
      hex_i  = 16'h1A3F;
      mode_i = 4'hF;
      pulse_load(1);
      wait_frame();
      exp_seg = '{7'h0E, 7'h30, 7'h08, 7'h79};
      push_frame(15, 4'hF);

      // Dim: prescaler 1..3 only
      wait_frame();
      bright_i = 3'd1;
      push_frame(3, 4'hF);
      repeat (10) @(negedge clk);
      blink_i = 4'b0100;
      pulse_load(1);

      // Blink on digit 2: frames 6,7,10 dark, 8,9 lit
      for (int f = 0; f < 5; f++) begin
         wait_frame();
         bright_i = 3'd7;
         push_frame(15, ((fcnt >> 1) & 1) != 0 ? 4'b1011 : 4'b1111);
      end

      // Reset mid-dwell of digit 1 with a load pending
      wait_frame();
      push_frame(15, 4'b0001);
      push_frame(3, 4'b0010);
      repeat (5) @(negedge clk);
      pulse_load(0);
      repeat (14) @(negedge clk);
      #1 rst = 1'b0;
      #1 chk_idle("mid_rst");
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      fcnt = 0;
      for (int f = 0; f < 3; f++)
         wait_frame();
      repeat (4) @(negedge clk);
      chk("runq_drained", runq.size(), 0);
      chk("ackq_drained", ackq.size(), 0);
      chk("post_rst_an", 32'(an_o), 32'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
